// File: rtl/sync_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// sync_fifo_stream_reader
//
// Read-side drain for the synchronous FIFO. Pops words from the FIFO read port
// and presents them on a valid/ready stream master, hiding the FIFO read
// latency from downstream. Works with the FIFO in FWFT mode (data valid in the
// read cycle) or standard mode (data valid one cycle after the read). A 2-entry
// output buffer sustains one word per cycle under continuous ready.
//
// Parameters:
//   DATA_WIDTH  word width, must match the FIFO data width
//   FWFT        1 = FIFO in FWFT mode, 0 = standard (1-cycle read latency)
//   CNT_WIDTH   width of the delivered-word counter
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           asynchronous active-high reset
//   enable_i        permits new FIFO reads; buffered/in-flight words still drain
//   fifo_empty_i    FIFO empty flag
//   fifo_read_o     FIFO read request (every assertion is a real pop)
//   fifo_rd_data_i  FIFO read data
//   m_valid_o       output word valid
//   m_ready_i       downstream accepts the word
//   m_data_o        output word (head of buffer)
//   busy_o          buffer non-empty or a read in flight
//   count_o         number of words delivered, wraps
// -----------------------------------------------------------------------------
module sync_fifo_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter bit FWFT       = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_read_o,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  count_o
);

    logic [1:0]            occ;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] second_q;
    logic                  pop;
    logic                  push;
    logic [2:0]            used;
    logic [2:0]            limit;

    assign pop = m_valid_o & m_ready_i;

    // A read may be issued only if its word is guaranteed a slot: buffered
    // plus in-flight words must stay below 2, counting the slot a pop in
    // this same cycle frees. Written as a comparison to avoid underflow.
    assign used  = {1'b0, occ} + {2'b00, inflight};
    assign limit = 3'd2 + {2'b00, pop};
    assign fifo_read_o = !rst_i & enable_i & !fifo_empty_i & (used < limit);

    // In FWFT mode the data is on the bus during the read cycle itself; in
    // standard mode it arrives in the cycle after the read.
    assign push = FWFT ? fifo_read_o : inflight;

    assign m_valid_o = (occ != 2'd0);
    assign busy_o    = m_valid_o | inflight;

    // Tracks the single outstanding standard-mode read; a back-to-back read
    // keeps it set while the previous word lands.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight <= 1'b0;
        end else begin
            inflight <= FWFT ? 1'b0 : fifo_read_o;
        end
    end

    // Output buffer: m_data_o is the head register, second_q the entry behind
    // it. On a pop the second entry moves up; a simultaneous push lands in
    // whichever slot becomes free so occupancy is unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ      <= 2'd0;
            m_data_o <= '0;
            second_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        m_data_o <= fifo_rd_data_i;
                    end else begin
                        second_q <= fifo_rd_data_i;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd2) begin
                        m_data_o <= second_q;
                    end
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        m_data_o <= fifo_rd_data_i;
                    end else begin
                        m_data_o <= second_q;
                        second_q <= fifo_rd_data_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Delivered-word counter, free-running wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (pop) begin
            count_o <= count_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_stream_reader
//
// Drives one FWFT-mode instance (index 0) and one standard-mode instance
// (index 1), each fed by a small FIFO model. Directed vectors with
// hand-computed timing, plus an order scoreboard per instance.
// -----------------------------------------------------------------------------
module tb_sync_fifo_stream_reader;

    localparam int DW = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic          enable [2];
    logic          ready  [2];
    logic          read   [2];
    logic          empty  [2];
    logic          valid  [2];
    logic          busy   [2];
    logic [DW-1:0] data   [2];
    logic [CW-1:0] count  [2];

    logic [DW-1:0] mem0 [256];
    logic [DW-1:0] mem1 [256];
    logic [7:0]    wp0 = 8'd0;
    logic [7:0]    rp0 = 8'd0;
    logic [7:0]    wp1 = 8'd0;
    logic [7:0]    rp1 = 8'd0;
    logic [DW-1:0] fwft_rd_data;
    logic [DW-1:0] std_rd_data = '0;

    logic [DW-1:0] exp0 [$];
    logic [DW-1:0] exp1 [$];

    int n_compared   = 0;
    int n_mismatched = 0;

    // FIFO models: FWFT shows the head word combinationally, standard mode
    // registers the word on the read edge.
    assign empty[0]     = (wp0 == rp0);
    assign empty[1]     = (wp1 == rp1);
    assign fwft_rd_data = mem0[rp0];

    always @(posedge clk) begin
        if (read[0]) rp0 <= rp0 + 8'd1;
    end

    always @(posedge clk) begin
        if (read[1]) begin
            std_rd_data <= mem1[rp1];
            rp1         <= rp1 + 8'd1;
        end
    end

    sync_fifo_stream_reader #(.DATA_WIDTH(DW), .FWFT(1'b1), .CNT_WIDTH(CW)) dut_fwft (
        .clk_i(clk), .rst_i(rst), .enable_i(enable[0]), .fifo_empty_i(empty[0]),
        .fifo_read_o(read[0]), .fifo_rd_data_i(fwft_rd_data), .m_valid_o(valid[0]),
        .m_ready_i(ready[0]), .m_data_o(data[0]), .busy_o(busy[0]), .count_o(count[0])
    );

    sync_fifo_stream_reader #(.DATA_WIDTH(DW), .FWFT(1'b0), .CNT_WIDTH(CW)) dut_std (
        .clk_i(clk), .rst_i(rst), .enable_i(enable[1]), .fifo_empty_i(empty[1]),
        .fifo_read_o(read[1]), .fifo_rd_data_i(std_rd_data), .m_valid_o(valid[1]),
        .m_ready_i(ready[1]), .m_data_o(data[1]), .busy_o(busy[1]), .count_o(count[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int m, input logic en, input logic rdy);
        enable[m] = en;
        ready[m]  = rdy;
    endtask

    task automatic fifo_write(input int m, input logic [DW-1:0] d);
        if (m == 0) begin
            mem0[wp0] = d;
            wp0 = wp0 + 8'd1;
            exp0.push_back(d);
        end else begin
            mem1[wp1] = d;
            wp1 = wp1 + 8'd1;
            exp1.push_back(d);
        end
    endtask

    function automatic logic [7:0] rd_ptr(input int m);
        return (m == 0) ? rp0 : rp1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle monitors: no read while empty, and words leave in FIFO order.
    always @(negedge clk) begin
        checkOutput("rd_while_empty0", 32'(read[0] & empty[0]), 32'd0);
        if (valid[0] && ready[0]) begin
            checkOutput("word_expected0", 32'(exp0.size() > 0), 32'd1);
            if (exp0.size() > 0) checkOutput("order0", 32'(data[0]), 32'(exp0.pop_front()));
        end
    end

    always @(negedge clk) begin
        checkOutput("rd_while_empty1", 32'(read[1] & empty[1]), 32'd0);
        if (valid[1] && ready[1]) begin
            checkOutput("word_expected1", 32'(exp1.size() > 0), 32'd1);
            if (exp1.size() > 0) checkOutput("order1", 32'(data[1]), 32'(exp1.pop_front()));
        end
    end

    // Preloaded stream with ready held high; first valid one cycle (FWFT) or
    // two cycles (standard) after the first read, then one word per cycle.
    task automatic stream_test(input int m);
        int lat;
        lat = (m == 0) ? 1 : 2;
        tick();
        for (int k = 0; k < 8; k++) fifo_write(m, 8'hA0 + 8'(k));
        applyStimulus(m, 1'b1, 1'b1);
        for (int i = 0; i < 10 + lat; i++) begin
            @(negedge clk);
            checkOutput($sformatf("stream%0d_read_c%0d", m, i), 32'(read[m]), 32'(i <= 7));
            checkOutput($sformatf("stream%0d_valid_c%0d", m, i), 32'(valid[m]),
                        32'((i >= lat) && (i <= 7 + lat)));
            if ((i >= lat) && (i <= 7 + lat))
                checkOutput($sformatf("stream%0d_data_c%0d", m, i), 32'(data[m]),
                            32'(8'hA0 + 8'(i - lat)));
        end
        checkOutput($sformatf("stream%0d_busy_end", m), 32'(busy[m]), 32'd0);
        checkOutput($sformatf("stream%0d_count", m), 32'(count[m]), 32'd8);
        tick();
        applyStimulus(m, 1'b0, 1'b1);
    endtask

    // Backpressure: exactly two reads fill the buffer, head held; on release
    // the remaining words follow back-to-back.
    task automatic backpressure_test(input int m, input logic [7:0] base);
        logic [7:0] start;
        tick();
        start = rd_ptr(m);
        for (int k = 0; k < 5; k++) fifo_write(m, base + 8'(k));
        applyStimulus(m, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                checkOutput($sformatf("bp%0d_hold_read_c%0d", m, i), 32'(read[m]), 32'd0);
                checkOutput($sformatf("bp%0d_hold_valid_c%0d", m, i), 32'(valid[m]), 32'd1);
                checkOutput($sformatf("bp%0d_hold_data_c%0d", m, i), 32'(data[m]), 32'(base));
            end
        end
        checkOutput($sformatf("bp%0d_reads", m), 32'(rd_ptr(m) - start), 32'd2);
        tick();
        applyStimulus(m, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("bp%0d_rel_valid_c%0d", m, i), 32'(valid[m]), 32'(i <= 4));
            if (i <= 4)
                checkOutput($sformatf("bp%0d_rel_data_c%0d", m, i), 32'(data[m]),
                            32'(base + 8'(i)));
        end
        checkOutput($sformatf("bp%0d_count", m), 32'(count[m]), 32'd13);
        tick();
        applyStimulus(m, 1'b0, 1'b1);
    endtask

    initial begin
        for (int m = 0; m < 2; m++) applyStimulus(m, 1'b0, 1'b1);

        // Reset state.
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            checkOutput($sformatf("rst%0d_valid", m), 32'(valid[m]), 32'd0);
            checkOutput($sformatf("rst%0d_busy", m), 32'(busy[m]), 32'd0);
            checkOutput($sformatf("rst%0d_count", m), 32'(count[m]), 32'd0);
            checkOutput($sformatf("rst%0d_data", m), 32'(data[m]), 32'd0);
            checkOutput($sformatf("rst%0d_read", m), 32'(read[m]), 32'd0);
        end
        #3 rst = 1'b0;

        stream_test(0);
        stream_test(1);
        backpressure_test(0, 8'hB0);
        backpressure_test(1, 8'hC0);

        // FWFT: FIFO runs dry mid-stream for three cycles, then one word.
        tick();
        fifo_write(0, 8'hD0);
        fifo_write(0, 8'hD1);
        applyStimulus(0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i >= 2) checkOutput($sformatf("empty_read_c%0d", i), 32'(read[0]), 32'd0);
            if (i >= 3) checkOutput($sformatf("empty_valid_c%0d", i), 32'(valid[0]), 32'd0);
        end
        tick();
        fifo_write(0, 8'hD2);
        @(negedge clk);
        checkOutput("empty_refill_read", 32'(read[0]), 32'd1);
        checkOutput("empty_refill_valid", 32'(valid[0]), 32'd0);
        @(negedge clk);
        checkOutput("empty_late_valid", 32'(valid[0]), 32'd1);
        checkOutput("empty_late_data", 32'(data[0]), 32'hD2);
        @(negedge clk);
        checkOutput("empty_done_valid", 32'(valid[0]), 32'd0);
        checkOutput("count_wrap16", 32'(count[0]), 32'd0);
        tick();
        applyStimulus(0, 1'b0, 1'b1);

        // Standard mode: enable falls the cycle after a read; in-flight word
        // still lands and is delivered, no further reads.
        tick();
        fifo_write(1, 8'hE0);
        fifo_write(1, 8'hE1);
        fifo_write(1, 8'hE2);
        applyStimulus(1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("en_first_read", 32'(read[1]), 32'd1);
        tick();
        applyStimulus(1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("en_off_read", 32'(read[1]), 32'd0);
        checkOutput("en_inflight_busy", 32'(busy[1]), 32'd1);
        checkOutput("en_inflight_valid", 32'(valid[1]), 32'd0);
        @(negedge clk);
        checkOutput("en_landed_valid", 32'(valid[1]), 32'd1);
        checkOutput("en_landed_data", 32'(data[1]), 32'hE0);
        @(negedge clk);
        checkOutput("en_busy_fall", 32'(busy[1]), 32'd0);
        checkOutput("en_valid_fall", 32'(valid[1]), 32'd0);
        checkOutput("en_count", 32'(count[1]), 32'd14);
        @(negedge clk);
        checkOutput("en_no_more_read", 32'(read[1]), 32'd0);

        // Async reset between edges with the FWFT buffer full.
        tick();
        fifo_write(0, 8'hF0);
        fifo_write(0, 8'hF1);
        fifo_write(0, 8'hF2);
        applyStimulus(0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("ar_full_valid", 32'(valid[0]), 32'd1);
        checkOutput("ar_full_data", 32'(data[0]), 32'hF0);
        #2 rst = 1'b1;
        #1;
        checkOutput("ar_valid", 32'(valid[0]), 32'd0);
        checkOutput("ar_busy", 32'(busy[0]), 32'd0);
        checkOutput("ar_count0", 32'(count[0]), 32'd0);
        checkOutput("ar_count1", 32'(count[1]), 32'd0);
        checkOutput("ar_data", 32'(data[0]), 32'd0);
        checkOutput("ar_read_gated", 32'(read[0]), 32'd0);
        void'(exp0.pop_front());
        void'(exp0.pop_front());
        @(posedge clk);
        #3;
        checkOutput("ar_hold_valid", 32'(valid[0]), 32'd0);
        checkOutput("ar_hold_read", 32'(read[0]), 32'd0);
        for (int k = 0; k < 16; k++) fifo_write(0, 8'h10 + 8'(k));
        applyStimulus(0, 1'b1, 1'b1);
        #3 rst = 1'b0;
        begin
            logic done;
            done = 1'b0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (empty[0] && !busy[0]) begin
                    done = 1'b1;
                    break;
                end
            end
            checkOutput("ar_drain_done", 32'(done), 32'd1);
        end
        checkOutput("ar_count_17", 32'(count[0]), 32'd1);
        checkOutput("ar_all_delivered", 32'(exp0.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
